// File: rtl/intersection_scheduler.sv
// Four-approach round-robin traffic scheduler: green -> yellow -> all-red, optional pedestrian walk.
// Optional pedestrian phase is enabled by defining PED_EN.
module intersection_scheduler #(
    parameter int TICK_DIV  = 50000000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_i,
    input  logic        ped_req_i,
    output logic [11:0] light_o,
    output logic [3:0]  grant_o,
    output logic [1:0]  phase_o,
    output logic        walk_o
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10,
        PH_WALK   = 2'b11
    } phase_t;

    phase_t          phase_reg, phase_next;
    logic [1:0]      owner_reg, owner_next;
    logic [1:0]      next_owner_reg, next_owner_next;
    logic [3:0]      pending_reg, pending_next;
    logic            ped_pend_reg, ped_pend_next;
    logic [7:0]      timer_reg, timer_next;
    logic [PW-1:0]   prescaler_reg, prescaler_next;
    logic [11:0]     light_reg, light_next;
    logic [3:0]      grant_reg, grant_next;
    logic            walk_reg, walk_next;

    logic            tick;
    logic [7:0]      timer_adv;
    logic [3:0]      owner_oh;
    logic [3:0]      pending_set;
    logic            other;
    logic            advance;
    logic [1:0]      arb_owner;
    logic            arb_found;
    logic [1:0]      cand;

    // timer_adv is the tick count after this edge, so phases end on exact tick boundaries
    assign tick      = (prescaler_reg == PW'(TICK_DIV - 1));
    assign timer_adv = (tick && timer_reg != 8'hFF) ? timer_reg + 8'd1 : timer_reg;
    assign owner_oh  = 4'b0001 << owner_reg;
    assign other     = (|(pending_reg & ~owner_oh)) | ped_pend_reg;

    always_comb begin
        arb_owner = owner_reg;
        arb_found = 1'b0;
        cand      = owner_reg;
        for (int i = 1; i < 4; i++) begin
            cand = owner_reg + 2'(i);
            if (!arb_found && pending_reg[cand]) begin
                arb_owner = cand;
                arb_found = 1'b1;
            end
        end
    end

    always_comb begin
        phase_next      = phase_reg;
        owner_next      = owner_reg;
        next_owner_next = next_owner_reg;
        advance         = 1'b0;
        pending_set     = req_i & ((phase_reg == PH_GREEN) ? ~owner_oh : 4'hF);

        case (phase_reg)
            PH_GREEN: begin
                if (other && (((timer_adv >= 8'(GREEN_MIN)) && !req_i[owner_reg]) ||
                              (timer_adv >= 8'(GREEN_MAX)))) begin
                    phase_next      = PH_YELLOW;
                    next_owner_next = arb_owner;
                    advance         = 1'b1;
                end
            end
            PH_YELLOW: begin
                if (timer_adv >= 8'(YELLOW_T)) begin
                    phase_next = PH_ALLRED;
                    advance    = 1'b1;
                end
            end
            PH_ALLRED: begin
                if (timer_adv >= 8'(ALLRED_T)) begin
                    advance = 1'b1;
                    if (ped_pend_reg) begin
                        phase_next = PH_WALK;
                    end else begin
                        phase_next = PH_GREEN;
                        owner_next = next_owner_reg;
                    end
                end
            end
            default: begin
                if (timer_adv >= 8'(WALK_T)) begin
                    phase_next = PH_GREEN;
                    owner_next = next_owner_reg;
                    advance    = 1'b1;
                end
            end
        endcase

        pending_next = pending_reg | pending_set;
        if (advance && phase_next == PH_GREEN) begin
            pending_next[owner_next] = 1'b0;
        end

        prescaler_next = (advance || tick) ? '0 : prescaler_reg + PW'(1);
        timer_next     = advance ? 8'd0 : timer_adv;
    end

`ifdef PED_EN
    assign ped_pend_next = (ped_pend_reg | ped_req_i) & ~(advance && phase_next == PH_WALK);
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req_i;
    assign ped_pend_next  = 1'b0;
`endif

    // Outputs are computed from the next state so they change on the transition edge
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_light
            assign light_next[3*gi +: 3] =
                (owner_next != 2'(gi))     ? 3'b100 :
                (phase_next == PH_GREEN)   ? 3'b001 :
                (phase_next == PH_YELLOW)  ? 3'b010 : 3'b100;
        end
    endgenerate

    assign grant_next = (phase_next == PH_GREEN || phase_next == PH_YELLOW) ?
                        (4'b0001 << owner_next) : 4'b0000;
    assign walk_next  = (phase_next == PH_WALK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg      <= PH_GREEN;
            owner_reg      <= 2'd0;
            next_owner_reg <= 2'd0;
            pending_reg    <= 4'd0;
            ped_pend_reg   <= 1'b0;
            timer_reg      <= 8'd0;
            prescaler_reg  <= '0;
            light_reg      <= 12'b100_100_100_001;
            grant_reg      <= 4'b0001;
            walk_reg       <= 1'b0;
        end else begin
            phase_reg      <= phase_next;
            owner_reg      <= owner_next;
            next_owner_reg <= next_owner_next;
            pending_reg    <= pending_next;
            ped_pend_reg   <= ped_pend_next;
            timer_reg      <= timer_next;
            prescaler_reg  <= prescaler_next;
            light_reg      <= light_next;
            grant_reg      <= grant_next;
            walk_reg       <= walk_next;
        end
    end

    assign light_o = light_reg;
    assign grant_o = grant_reg;
    assign phase_o = phase_reg;
    assign walk_o  = walk_reg;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed self-checking bench for intersection_scheduler (TICK_DIV=4, GREEN_MIN=2, GREEN_MAX=5,
// YELLOW_T=1, ALLRED_T=1, WALK_T=2); observed vector is {light_o, grant_o, phase_o, walk_o}.
module tb_intersection_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_i;
    logic        ped_req_i;
    logic [11:0] light_o;
    logic [3:0]  grant_o;
    logic [1:0]  phase_o;
    logic        walk_o;

    int vectors;
    int miscompares;

    localparam logic [11:0] L_G0  = 12'b100_100_100_001;
    localparam logic [11:0] L_Y0  = 12'b100_100_100_010;
    localparam logic [11:0] L_G1  = 12'b100_100_001_100;
    localparam logic [11:0] L_G2  = 12'b100_001_100_100;
    localparam logic [11:0] L_RED = 12'b100_100_100_100;

    localparam logic [18:0] V_G0   = {L_G0,  4'b0001, 2'b00, 1'b0};
    localparam logic [18:0] V_Y0   = {L_Y0,  4'b0001, 2'b01, 1'b0};
    localparam logic [18:0] V_AR   = {L_RED, 4'b0000, 2'b10, 1'b0};
    localparam logic [18:0] V_G1   = {L_G1,  4'b0010, 2'b00, 1'b0};
    localparam logic [18:0] V_G2   = {L_G2,  4'b0100, 2'b00, 1'b0};
    localparam logic [18:0] V_WALK = {L_RED, 4'b0000, 2'b11, 1'b1};

    intersection_scheduler #(
        .TICK_DIV (4),
        .GREEN_MIN(2),
        .GREEN_MAX(5),
        .YELLOW_T (1),
        .ALLRED_T (1),
        .WALK_T   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .ped_req_i(ped_req_i),
        .light_o  (light_o),
        .grant_o  (grant_o),
        .phase_o  (phase_o),
        .walk_o   (walk_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety: at most one approach may be non-red in any cycle, and only legal light codes appear
    always @(negedge clk) begin
        if (rst_n) begin
            int nonred;
            logic bad_code;
            nonred   = 0;
            bad_code = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (light_o[3*k +: 3] != 3'b100) nonred++;
                if (light_o[3*k +: 3] != 3'b100 && light_o[3*k +: 3] != 3'b010 &&
                    light_o[3*k +: 3] != 3'b001) bad_code = 1'b1;
            end
            vectors++;
            if (nonred > 1 || bad_code) begin
                miscompares++;
                $display("FAIL safety: light_o=%b has %0d non-red approaches (required <=1, legal codes)",
                         light_o, nonred);
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        req_i     = 4'b0000;
        ped_req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 200; c++) begin
            vectors++;
            if ({light_o, grant_o, phase_o, walk_o} !== V_G0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: got %b required %b", c,
                         {light_o, grant_o, phase_o, walk_o}, V_G0);
            end
            @(negedge clk);
        end
        $display("test_reset: 200 idle cycles checked");
    endtask

    task automatic test_gap_out();
        int          cnt[3];
        logic [18:0] ex[3];
        cnt = '{4, 4, 30};
        ex  = '{V_Y0, V_AR, V_G2};
        do_reset();
        repeat (20) @(negedge clk);
        req_i = 4'b0100;
        @(negedge clk);
        req_i = 4'b0000;
        vectors++;
        if ({light_o, grant_o, phase_o, walk_o} !== V_G0) begin
            miscompares++;
            $display("FAIL gap_out_latch: got %b required %b", {light_o, grant_o, phase_o, walk_o}, V_G0);
        end
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < cnt[s]; c++) begin
                @(negedge clk);
                vectors++;
                if ({light_o, grant_o, phase_o, walk_o} !== ex[s]) begin
                    miscompares++;
                    $display("FAIL gap_out step %0d cycle %0d: got %b required %b", s, c,
                             {light_o, grant_o, phase_o, walk_o}, ex[s]);
                end
            end
        end
        $display("test_gap_out: approach 2 served after yellow and all-red");
    endtask

    task automatic test_max_out();
        int          green_cycles;
        int          cnt[3];
        logic [18:0] ex[3];
        cnt = '{3, 4, 1};
        ex  = '{V_Y0, V_AR, V_G1};
        do_reset();
        req_i = 4'b0011;
        vectors++;
        if ({light_o, grant_o, phase_o, walk_o} !== V_G0) begin
            miscompares++;
            $display("FAIL max_out_entry: got %b required %b", {light_o, grant_o, phase_o, walk_o}, V_G0);
        end
        green_cycles = 1;
        @(negedge clk);
        req_i = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            if (phase_o != 2'b00) break;
            green_cycles++;
            @(negedge clk);
        end
        vectors++;
        if (green_cycles != 20) begin
            miscompares++;
            $display("FAIL max_out_length: got %0d green cycles required 20", green_cycles);
        end
        vectors++;
        if ({light_o, grant_o, phase_o, walk_o} !== V_Y0) begin
            miscompares++;
            $display("FAIL max_out_yellow: got %b required %b", {light_o, grant_o, phase_o, walk_o}, V_Y0);
        end
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < cnt[s]; c++) begin
                @(negedge clk);
                vectors++;
                if ({light_o, grant_o, phase_o, walk_o} !== ex[s]) begin
                    miscompares++;
                    $display("FAIL max_out step %0d cycle %0d: got %b required %b", s, c,
                             {light_o, grant_o, phase_o, walk_o}, ex[s]);
                end
            end
        end
        req_i = 4'b0000;
        $display("test_max_out: green held %0d cycles under continuous demand", green_cycles);
    endtask

    task automatic test_round_robin();
        logic [1:0] prev_phase;
        int         run;
        int         ngr;
        logic [3:0] grants[3];
        logic [3:0] exp_grants[3];
        exp_grants = '{4'b0010, 4'b0100, 4'b1000};
        grants     = '{4'b0000, 4'b0000, 4'b0000};
        do_reset();
        repeat (10) @(negedge clk);
        req_i = 4'b1110;
        @(negedge clk);
        req_i      = 4'b0000;
        prev_phase = phase_o;
        run        = 1;
        ngr        = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (phase_o != prev_phase) begin
                vectors++;
                if (!((prev_phase == 2'b00 && phase_o == 2'b01) ||
                      (prev_phase == 2'b01 && phase_o == 2'b10) ||
                      (prev_phase == 2'b10 && phase_o == 2'b00))) begin
                    miscompares++;
                    $display("FAIL rr_transition: got phase %b after %b required legal successor",
                             phase_o, prev_phase);
                end
                if (prev_phase == 2'b01 || prev_phase == 2'b10) begin
                    vectors++;
                    if (run != 4) begin
                        miscompares++;
                        $display("FAIL rr_clearance_len phase %b: got %0d cycles required 4", prev_phase, run);
                    end
                end
                if (phase_o == 2'b00) begin
                    if (ngr < 3) grants[ngr] = grant_o;
                    ngr++;
                end
                run = 1;
            end else begin
                run++;
            end
            prev_phase = phase_o;
        end
        vectors++;
        if (ngr != 3) begin
            miscompares++;
            $display("FAIL rr_grant_count: got %0d greens required 3", ngr);
        end
        for (int g = 0; g < 3; g++) begin
            vectors++;
            if (grants[g] !== exp_grants[g]) begin
                miscompares++;
                $display("FAIL rr_order %0d: got %b required %b", g, grants[g], exp_grants[g]);
            end
        end
        vectors++;
        if ({phase_o, grant_o} !== {2'b00, 4'b1000}) begin
            miscompares++;
            $display("FAIL rr_rest: got phase %b grant %b required 00 1000", phase_o, grant_o);
        end
        $display("test_round_robin: grants %b %b %b", grants[0], grants[1], grants[2]);
    endtask

`ifdef PED_EN
    task automatic test_ped();
        int          green_cycles;
        int          cnt[5];
        logic [18:0] ex[5];
        cnt = '{3, 4, 8, 1, 0};
        ex  = '{V_Y0, V_AR, V_WALK, V_G0, V_G0};
        do_reset();
        ped_req_i    = 1'b1;
        green_cycles = 1;
        @(negedge clk);
        ped_req_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (phase_o != 2'b00) break;
            green_cycles++;
            @(negedge clk);
        end
        vectors++;
        if (green_cycles != 8) begin
            miscompares++;
            $display("FAIL ped_gap_out: got %0d green cycles required 8", green_cycles);
        end
        vectors++;
        if ({light_o, grant_o, phase_o, walk_o} !== V_Y0) begin
            miscompares++;
            $display("FAIL ped_yellow: got %b required %b", {light_o, grant_o, phase_o, walk_o}, V_Y0);
        end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < cnt[s]; c++) begin
                @(negedge clk);
                vectors++;
                if ({light_o, grant_o, phase_o, walk_o} !== ex[s]) begin
                    miscompares++;
                    $display("FAIL ped step %0d cycle %0d: got %b required %b", s, c,
                             {light_o, grant_o, phase_o, walk_o}, ex[s]);
                end
            end
        end
        $display("test_ped: walk phase served, approach 0 restored");
    endtask
`else
    task automatic test_ped();
        do_reset();
        ped_req_i = 1'b1;
        @(negedge clk);
        ped_req_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            vectors++;
            if ({light_o, grant_o, phase_o, walk_o} !== V_G0) begin
                miscompares++;
                $display("FAIL ped_ignored cycle %0d: got %b required %b", c,
                         {light_o, grant_o, phase_o, walk_o}, V_G0);
            end
        end
        $display("test_ped: pedestrian button ignored without the walk phase");
    endtask
`endif

    task automatic test_reset_mid_yellow();
        do_reset();
        repeat (10) @(negedge clk);
        req_i = 4'b1010;
        @(negedge clk);
        req_i = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({light_o, grant_o, phase_o, walk_o} !== V_Y0) begin
            miscompares++;
            $display("FAIL rst_pre_yellow: got %b required %b", {light_o, grant_o, phase_o, walk_o}, V_Y0);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({light_o, grant_o, phase_o, walk_o} !== V_G0) begin
            miscompares++;
            $display("FAIL rst_async: got %b required %b", {light_o, grant_o, phase_o, walk_o}, V_G0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            vectors++;
            if ({light_o, grant_o, phase_o, walk_o} !== V_G0) begin
                miscompares++;
                $display("FAIL rst_rest cycle %0d: got %b required %b", c,
                         {light_o, grant_o, phase_o, walk_o}, V_G0);
            end
        end
        $display("test_reset_mid_yellow: pending discarded, resting on approach 0");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_i       = 4'b0000;
        ped_req_i   = 1'b0;
        test_reset();
        test_gap_out();
        test_max_out();
        test_round_robin();
        test_ped();
        test_reset_mid_yellow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
